ha_iter_add_seq: RTL and testbench

Multi-cycle N-bit adder controller built on a bitwise half-adder array, where each bit computes sum=x^y and carry=x&y. The block accepts an operand pair over a valid/ready handshake. It then feeds the half-adder array once per clock, using the shifted carry as the next operand, until the carry vector is zero. It presents sum, carry-out and iteration count over an output valid/ready handshake.

---
 rtl/ha_iter_add_seq_if.sv | 32 +++
 rtl/ha_iter_add_seq.sv | 113 +++++++++++
 tb/tb_ha_iter_add_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ha_iter_add_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ha_iter_add_seq_if : operand / result handshake bundle             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ha_iter_add_seq_if #(
   parameter int N = 4
);
   localparam int ITER_W = $clog2(N + 1);

   logic              in_valid;
   logic              in_ready;
   logic [N-1:0]      a;
   logic [N-1:0]      b;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      sum;
   logic              cout;
   logic [ITER_W-1:0] iters;
   logic              busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum, cout, iters, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum, cout, iters, busy
   );
endinterface
`default_nettype wire

// File: rtl/ha_iter_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ha_iter_add_seq : iterative adder on a bitwise half-adder array    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ha_iter_add_seq #(
   parameter int N = 4
) (
   input wire logic         clk,
   input wire logic         rst,
   ha_iter_add_seq_if.slave io
);
   localparam int ITER_W = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [N-1:0]      r_x;
   logic [N-1:0]      r_y;
   logic              r_cacc;
   logic [ITER_W-1:0] r_cnt;
   logic [N-1:0]      r_sum;
   logic              r_cout;
   logic [ITER_W-1:0] r_iters;

   logic [N-1:0]      w_hs;
   logic [N-1:0]      w_hc;
   logic [N-1:0]      w_y_next;
   logic              w_y_zero;
   logic              w_accept;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ha
         assign w_hs[gi] = r_x[gi] ^ r_y[gi];
         assign w_hc[gi] = r_x[gi] & r_y[gi];
      end
   endgenerate

   // The MSB carry leaves the word here; it is folded into r_cacc instead.
   assign w_y_next = {w_hc[N-2:0], 1'b0};
   assign w_y_zero = (r_y == '0);
   assign w_accept = io.in_valid && (r_state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = S_RUN;
         S_RUN:  if (w_y_zero) w_next_state = S_DONE;
         S_DONE: if (io.out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      io.in_ready  = (r_state == S_IDLE);
      io.busy      = (r_state == S_RUN);
      io.out_valid = (r_state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x     <= '0;
         r_y     <= '0;
         r_cacc  <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_iters <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x    <= io.a;
                  r_y    <= io.b;
                  r_cacc <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               if (!w_y_zero) begin
                  r_x    <= w_hs;
                  r_y    <= w_y_next;
                  r_cacc <= r_cacc | w_hc[N-1];
                  r_cnt  <= r_cnt + ITER_W'(1);
               end else begin
                  r_sum   <= r_x;
                  r_cout  <= r_cacc;
                  r_iters <= r_cnt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign io.sum   = r_sum;
   assign io.cout  = r_cout;
   assign io.iters = r_iters;
endmodule
`default_nettype wire

// File: tb/tb_ha_iter_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ha_iter_add_seq : table, corner and random checks, N=4 and N=8  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ha_iter_add_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ha_iter_add_seq_if #(.N(4)) if4 ();
   ha_iter_add_seq_if #(.N(8)) if8 ();

   ha_iter_add_seq #(.N(4)) dut4 (.clk(clk), .rst(rst), .io(if4.slave));
   ha_iter_add_seq #(.N(8)) dut8 (.clk(clk), .rst(rst), .io(if8.slave));

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] s;
      logic       c;
      logic [2:0] it;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Reference: true sum/carry from integer addition; pass count by repeating
   // the half-adder rule on plain integers until no carries remain.
   task automatic ref_add(input int n, input int a, input int b,
                          output int s, output int co, output int it);
      int x, y, g, mask;
      mask = (1 << n) - 1;
      s    = (a + b) & mask;
      co   = (a + b) >> n;
      x    = a;
      y    = b;
      it   = 0;
      while (y != 0) begin
         g  = x & y;
         x  = x ^ y;
         y  = (g << 1) & mask;
         it = it + 1;
      end
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input int hold,
                      output logic [3:0] s, output logic c, output logic [2:0] it,
                      output int lat);
      @(negedge clk);
      chk("in_ready_idle4", if4.in_ready, 1);
      if4.a = a; if4.b = b; if4.in_valid = 1'b1;
      @(posedge clk); #1;
      if4.in_valid = 1'b0; if4.a = 4'($urandom); if4.b = 4'($urandom);
      lat = 0;
      while (!if4.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!if4.out_valid) chk("timeout4", 0, 1);
      s = if4.sum; c = if4.cout; it = if4.iters;
      repeat (hold) begin
         if4.in_valid = 1'($urandom); if4.a = 4'($urandom); if4.b = 4'($urandom);
         @(posedge clk); #1;
         chk("bp_out_valid4", if4.out_valid, 1);
         chk("bp_in_ready4", if4.in_ready, 0);
         chk("bp_hold4", {if4.cout, if4.sum, if4.iters}, {c, s, it});
      end
      if4.in_valid = 1'b0;
      if4.out_ready = 1'b1;
      @(posedge clk); #1;
      if4.out_ready = 1'b0;
      chk("handoff_ov4", if4.out_valid, 0);
      chk("handoff_ir4", if4.in_ready, 1);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold,
                      output logic [7:0] s, output logic c, output logic [3:0] it,
                      output int lat);
      @(negedge clk);
      if8.a = a; if8.b = b; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
      lat = 0;
      while (!if8.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!if8.out_valid) chk("timeout8", 0, 1);
      s = if8.sum; c = if8.cout; it = if8.iters;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("bp_hold8", {if8.out_valid, if8.cout, if8.sum, if8.iters}, {1'b1, c, s, it});
      end
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
      chk("handoff_ov8", if8.out_valid, 0);
   endtask

   initial begin
      logic [7:0] s;
      logic       c;
      logic [3:0] it;
      int         lat, rs, rc, ri, ra, rb, seen, n;

      if4.in_valid = 0; if4.a = 0; if4.b = 0; if4.out_ready = 0;
      if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.out_ready = 0;

      tbl[0] = '{4'd5,  4'd3, 4'd8,  1'b0, 3'd4};
      tbl[1] = '{4'd15, 4'd1, 4'd0,  1'b1, 3'd4};
      tbl[2] = '{4'd8,  4'd8, 4'd0,  1'b1, 3'd1};
      tbl[3] = '{4'd0,  4'd0, 4'd0,  1'b0, 3'd0};
      tbl[4] = '{4'd9,  4'd6, 4'd15, 1'b0, 3'd1};

      #1;
      chk("rst_in_ready", if4.in_ready, 1);
      chk("rst_out_valid", if4.out_valid, 0);
      chk("rst_busy", if4.busy, 0);
      chk("rst_result", {if4.cout, if4.sum, if4.iters}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         op4(tbl[i].a, tbl[i].b, 0, s[3:0], c, it[2:0], lat);
         chk("vec_sum", s[3:0], tbl[i].s);
         chk("vec_cout", c, tbl[i].c);
         chk("vec_iters", it[2:0], tbl[i].it);
         chk("vec_latency", lat, tbl[i].it + 1);
      end

      // Reset two cycles into a run, with a nonzero previous result on the outputs.
      @(negedge clk);
      if4.a = 4'd15; if4.b = 4'd1; if4.in_valid = 1'b1;
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; #1;
      chk("mid_rst_in_ready", if4.in_ready, 1);
      chk("mid_rst_out_valid", if4.out_valid, 0);
      chk("mid_rst_busy", if4.busy, 0);
      chk("mid_rst_result", {if4.cout, if4.sum, if4.iters}, 0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (if4.out_valid || if4.busy) seen = 1;
      end
      chk("no_stale", seen, 0);

      // Backpressure with toggling inputs.
      op4(4'd5, 4'd3, 5, s[3:0], c, it[2:0], lat);
      chk("bp_sum", {c, s[3:0]}, 8);
      chk("bp_iters", it[2:0], 4);

      // in_valid held across handoff: no accept until the edge after IDLE.
      @(negedge clk);
      if4.a = 4'd9; if4.b = 4'd6; if4.in_valid = 1'b1;
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      lat = 0;
      while (!if4.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk("ho_first_valid", if4.out_valid, 1);
      if4.a = 4'd0; if4.b = 4'd0; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
      @(posedge clk); #1;
      if4.out_ready = 1'b0;
      chk("ho_idle_ov", if4.out_valid, 0);
      chk("ho_idle_ir", if4.in_ready, 1);
      chk("ho_idle_busy", if4.busy, 0);
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      chk("ho_accept_busy", if4.busy, 1);
      chk("ho_accept_ir", if4.in_ready, 0);
      @(posedge clk); #1;
      chk("ho_zero_done", {if4.out_valid, if4.cout, if4.sum, if4.iters}, {1'b1, 8'd0});
      if4.out_ready = 1'b1;
      @(posedge clk); #1;
      if4.out_ready = 1'b0;

      for (int i = 0; i < 40; i++) begin
         n  = (i < 20) ? 4 : 8;
         ra = int'($urandom_range(0, (1 << n) - 1));
         rb = int'($urandom_range(0, (1 << n) - 1));
         ref_add(n, ra, rb, rs, rc, ri);
         if (n == 4) begin
            op4(4'(ra), 4'(rb), int'($urandom_range(0, 3)), s[3:0], c, it[2:0], lat);
            s[7:4] = 4'd0; it[3] = 1'b0;
         end else begin
            op8(8'(ra), 8'(rb), int'($urandom_range(0, 3)), s, c, it, lat);
         end
         chk("rnd_sum", {c, s}, rc * 256 + rs);
         chk("rnd_iters", it, ri);
         chk("rnd_iters_le_n", (int'(it) <= n) ? 1 : 0, 1);
         chk("rnd_latency", lat, ri + 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
